key_debounce_scheduler: RTL

Time-shares one debounce timer across NUM_KEYS active-low push-buttons, replacing one counter per key.
- A round-robin scheduler picks a key whose raw level differs from its debounced level.
- It runs the shared timer on that key and commits the new level when the key is stable.
- It emits a one-cycle press pulse and keeps a per-key press counter.
- Sits between board button pins and user logic (mode select, counters, display).

---
 rtl/key_debounce_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/key_debounce_scheduler.sv
// Debounces NUM_KEYS active-low buttons with a single shared timer that a
// round-robin scheduler hands to one key at a time.
module key_debounce_scheduler #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 999_999,
  parameter int CNT_W           = 4,
  localparam int ID_W           = $clog2(NUM_KEYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS-1:0]       key_in,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       press_pulse,
  output logic [NUM_KEYS*CNT_W-1:0] press_cnt,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id
);

  localparam int TMR_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(DEBOUNCE_CYCLES);
  localparam logic [ID_W:0]    KEYS_EXT = (ID_W+1)'(NUM_KEYS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Two-flop synchronizer; buttons idle high, so the flops reset to released.
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  logic [NUM_KEYS-1:0]            r_key_level;
  logic [NUM_KEYS-1:0]            r_press_pulse;
  logic [NUM_KEYS-1:0][CNT_W-1:0] r_cnt;

  state_t          r_state;
  state_t          w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic [ID_W-1:0] r_active_id;
  logic [ID_W-1:0] w_active_next;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] w_last_next;
  logic            r_busy;
  logic            w_commit;

  logic [NUM_KEYS-1:0] w_pressed_raw;
  logic [NUM_KEYS-1:0] w_mismatch;
  logic [NUM_KEYS-1:0] w_commit_sel;
  logic                w_grant_valid;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W:0]       w_idx;

  assign w_pressed_raw = ~r_sync2;
  assign w_mismatch    = w_pressed_raw ^ r_key_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Round-robin search: first mismatching key after last_grant, wrapping.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_idx         = '0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      w_idx = {1'b0, r_last_grant} + (ID_W+1)'(k);
      if (w_idx >= KEYS_EXT) begin
        w_idx = w_idx - KEYS_EXT;
      end
      if (!w_grant_valid && w_mismatch[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_active_id  <= '0;
      r_last_grant <= ID_W'(NUM_KEYS - 1);
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_active_id  <= w_active_next;
      r_last_grant <= w_last_next;
      r_busy       <= (w_state_next != ST_IDLE);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_active_next = r_active_id;
    w_last_next   = r_last_grant;
    w_commit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_active_next = w_grant_id;
          w_timer_next  = '0;
          w_state_next  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // A key that returns to its committed level forfeits the timer.
        if (!w_mismatch[r_active_id]) begin
          w_last_next  = r_active_id;
          w_timer_next = '0;
          w_state_next = ST_IDLE;
        end else if (r_timer == TMR_MAX) begin
          w_state_next = ST_COMMIT;
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      ST_COMMIT: begin
        w_commit     = 1'b1;
        w_last_next  = r_active_id;
        w_timer_next = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_timer_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_sel
      assign w_commit_sel[gi] = w_commit && (r_active_id == ID_W'(gi));
    end
  endgenerate

  // Only a 0->1 commit is a press; releases just clear the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_level   <= '0;
      r_press_pulse <= '0;
      r_cnt         <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_press_pulse[k] <= w_commit_sel[k] && !r_key_level[k];
        if (w_commit_sel[k]) begin
          r_key_level[k] <= ~r_key_level[k];
          if (!r_key_level[k]) begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign key_level   = r_key_level;
  assign press_pulse = r_press_pulse;
  assign press_cnt   = r_cnt;
  assign busy        = r_busy;
  assign active_id   = r_active_id;

endmodule
